// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, combinational fetch lookup and saturating misprediction statistics.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Branch,
  input  logic [31:0]      PC,
  output logic             Prediction,
  output logic [31:0]      PredictedTarget,
  input  logic             UpdateEnable,
  input  logic [31:0]      PCUpdate,
  input  logic             BranchTaken,
  input  logic [31:0]      PCBranch,
  input  logic             PredictionUpdate,
  input  logic             Flush,
  input  logic             ClearStats,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  // Table storage kept as packed vectors so reset and flush are whole-vector writes.
  logic [ENTRIES-1:0]                valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag_q;
  logic [ENTRIES-1:0][31:0]          target_q;
  logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q;

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  // Fetch-side lookup.
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = PC[IDX+1:2];
  assign lk_tag = PC[31:IDX+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign Prediction      = Branch && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign PredictedTarget = target_q[lk_idx];

  // Decode-side training.
  logic [IDX-1:0]      up_idx;
  logic [TAG_W-1:0]    up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] up_ctr;
  logic [CTR_BITS-1:0] ctr_inc;
  logic [CTR_BITS-1:0] ctr_dec;

  assign up_idx = PCUpdate[IDX+1:2];
  assign up_tag = PCUpdate[31:IDX+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    ctr_inc = up_ctr;
    ctr_dec = up_ctr;
    if (up_ctr != CTR_MAX) ctr_inc = up_ctr + CTR_BITS'(1);
    if (up_ctr != '0)      ctr_dec = up_ctr - CTR_BITS'(1);
  end

  // Flush only drops valid bits; targets and counters are retained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{CTR_WNT}};
    end else if (Flush) begin
      valid_q <= '0;
    end else if (UpdateEnable) begin
      if (up_hit) begin
        if (BranchTaken) begin
          ctr_q[up_idx]    <= ctr_inc;
          target_q[up_idx] <= PCBranch;
        end else begin
          ctr_q[up_idx] <= ctr_dec;
        end
      end else if (BranchTaken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= PCBranch;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  // Statistics run independently of Flush; ClearStats beats any increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (ClearStats) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (UpdateEnable) begin
      if (branch_cnt_q != CNT_MAX) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if ((BranchTaken != PredictionUpdate) && (miss_cnt_q != CNT_MAX))
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign BranchCount = branch_cnt_q;
  assign MissCount   = miss_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[1:0], PCUpdate[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic,
// checked against an array-based behavioural model of the table and statistics.
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int CNT_W    = 4;
  localparam int IDX      = $clog2(ENTRIES);
  localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             Branch = 1'b0;
  logic [31:0]      PC = '0;
  logic             Prediction;
  logic [31:0]      PredictedTarget;
  logic             UpdateEnable = 1'b0;
  logic [31:0]      PCUpdate = '0;
  logic             BranchTaken = 1'b0;
  logic [31:0]      PCBranch = '0;
  logic             PredictionUpdate = 1'b0;
  logic             Flush = 1'b0;
  logic             ClearStats = 1'b0;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MissCount;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Branch(Branch), .PC(PC),
    .Prediction(Prediction), .PredictedTarget(PredictedTarget),
    .UpdateEnable(UpdateEnable), .PCUpdate(PCUpdate), .BranchTaken(BranchTaken),
    .PCBranch(PCBranch), .PredictionUpdate(PredictionUpdate), .Flush(Flush),
    .ClearStats(ClearStats), .BranchCount(BranchCount), .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per entry, counters as plain integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_target[ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_bc;
  int          m_mc;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = (1 << (CTR_BITS - 1)) - 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic logic exp_pred(logic br, logic [31:0] pc);
    int unsigned i;
    i = idx_of(pc);
    return br && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= (1 << (CTR_BITS - 1)));
  endfunction

  function automatic logic [31:0] exp_target(logic [31:0] pc);
    return m_target[idx_of(pc)];
  endfunction

  function automatic void model_edge();
    int unsigned i;
    bit hit;
    i   = idx_of(PCUpdate);
    hit = m_valid[i] && (m_tag[i] == tag_of(PCUpdate));
    if (Flush) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (UpdateEnable) begin
      if (hit && BranchTaken) begin
        m_ctr[i]    = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
        m_target[i] = PCBranch;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (BranchTaken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(PCUpdate);
        m_target[i] = PCBranch;
        m_ctr[i]    = 1 << (CTR_BITS - 1);
      end
    end
    if (ClearStats) begin
      m_bc = 0;
      m_mc = 0;
    end else if (UpdateEnable) begin
      if (m_bc < CNT_TOP) m_bc++;
      if ((BranchTaken != PredictionUpdate) && (m_mc < CNT_TOP)) m_mc++;
    end
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge and are
  // sampled by the checks 1 time unit later, well clear of the next edge.
  task automatic set_update(input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic pred);
    UpdateEnable     = 1'b1;
    PCUpdate         = pc;
    BranchTaken      = taken;
    PCBranch         = tgt;
    PredictionUpdate = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    UpdateEnable = 1'b0;
    Flush        = 1'b0;
    ClearStats   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Branch = 1'b1;
    PC     = 32'h100;
    model_reset();
    #2;
    n_checks++;
    if (Prediction !== 1'b0 || PredictedTarget !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_reset got pred=%0b tgt=%h exp pred=0 tgt=0", Prediction, PredictedTarget);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
      n_fail++;
      $display("FAIL reset_lookup got pred=%0b tgt=%h exp pred=%0b tgt=%h",
               Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
    end
    n_checks++;
    if (BranchCount !== CNT_W'(m_bc) || MissCount !== CNT_W'(m_mc)) begin
      n_fail++;
      $display("FAIL reset_stats got bc=%0d mc=%0d exp bc=%0d mc=%0d", BranchCount, MissCount, m_bc, m_mc);
    end
  endtask

  task automatic test_allocate();
    Branch = 1'b1;
    PC     = 32'h100;
    set_update(32'h100, 1'b1, 32'h200, 1'b0);
    #1;
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC)) begin
      n_fail++;
      $display("FAIL alloc_same_cycle got %0b exp %0b", Prediction, exp_pred(Branch, PC));
    end
    tick();
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
      n_fail++;
      $display("FAIL alloc_lookup got pred=%0b tgt=%h exp pred=%0b tgt=%h",
               Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
    end
    n_checks++;
    if (BranchCount !== CNT_W'(m_bc) || MissCount !== CNT_W'(m_mc)) begin
      n_fail++;
      $display("FAIL alloc_stats got bc=%0d mc=%0d exp bc=%0d mc=%0d", BranchCount, MissCount, m_bc, m_mc);
    end
    Branch = 1'b0;
    #1;
    n_checks++;
    if (Prediction !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_no_branch got %0b exp 0", Prediction);
    end
  endtask

  task automatic test_alias();
    Branch = 1'b1;
    PC     = 32'h140;
    #1;
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
      n_fail++;
      $display("FAIL alias_tag_miss got pred=%0b tgt=%h exp pred=%0b tgt=%h",
               Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
    end
    set_update(32'h140, 1'b1, 32'h300, 1'b0);
    tick();
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
      n_fail++;
      $display("FAIL alias_alloc got pred=%0b tgt=%h exp pred=%0b tgt=%h",
               Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
    end
    PC = 32'h100;
    #1;
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC)) begin
      n_fail++;
      $display("FAIL alias_evicted got %0b exp %0b", Prediction, exp_pred(Branch, PC));
    end
  endtask

  task automatic test_saturation();
    // Direction sequence after a fresh allocation: 3 taken, 4 not taken, 2 taken.
    logic dirs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    Branch = 1'b1;
    PC     = 32'h504;
    set_update(32'h504, 1'b1, 32'h5a0, 1'b1);
    tick();
    for (int s = 0; s < 9; s++) begin
      set_update(32'h504, dirs[s], 32'h5a0 + 32'(s * 4), 1'b1);
      tick();
      n_checks++;
      if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
        n_fail++;
        $display("FAIL sat_step%0d got pred=%0b tgt=%h exp pred=%0b tgt=%h", s,
                 Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] pcs[4] = '{32'h100, 32'h140, 32'h504, 32'h400};
    int bc_before;
    bc_before = m_bc;
    Flush = 1'b1;
    set_update(32'h400, 1'b1, 32'h480, 1'b1);
    tick();
    Branch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      PC = pcs[k];
      #1;
      n_checks++;
      if (Prediction !== 1'b0 || PredictedTarget !== exp_target(PC)) begin
        n_fail++;
        $display("FAIL flush_lookup pc=%h got pred=%0b tgt=%h exp pred=0 tgt=%h",
                 PC, Prediction, PredictedTarget, exp_target(PC));
      end
    end
    n_checks++;
    if (BranchCount !== CNT_W'(m_bc) || m_bc != bc_before + 1) begin
      n_fail++;
      $display("FAIL flush_stats got bc=%0d exp bc=%0d", BranchCount, m_bc);
    end
  endtask

  task automatic test_stats_saturation();
    ClearStats = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      set_update(32'h7fc, 1'b0, 32'h0, 1'b1);
      tick();
    end
    n_checks++;
    if (MissCount !== CNT_W'(CNT_TOP) || BranchCount !== CNT_W'(m_bc)) begin
      n_fail++;
      $display("FAIL stats_saturate got bc=%0d mc=%0d exp bc=%0d mc=%0d", BranchCount, MissCount, m_bc, CNT_TOP);
    end
    set_update(32'h7fc, 1'b1, 32'h0, 1'b0);
    ClearStats = 1'b1;
    tick();
    n_checks++;
    if (BranchCount !== 4'd0 || MissCount !== 4'd0) begin
      n_fail++;
      $display("FAIL stats_clear got bc=%0d mc=%0d exp bc=0 mc=0", BranchCount, MissCount);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Branch = 1'($urandom_range(0, 1));
      PC     = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3))} << 0;
      PC     = (32'($urandom_range(0, 2)) << (IDX + 2)) | (32'($urandom_range(0, 15)) << 2);
      set_update((32'($urandom_range(0, 2)) << (IDX + 2)) | (32'($urandom_range(0, 15)) << 2),
                 1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)));
      UpdateEnable = ($urandom_range(0, 3) != 0);
      Flush        = ($urandom_range(0, 24) == 0);
      ClearStats   = ($urandom_range(0, 39) == 0);
      #1;
      n_checks++;
      if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC)) begin
        n_fail++;
        $display("FAIL rand_lookup it=%0d pc=%h got pred=%0b tgt=%h exp pred=%0b tgt=%h", n, PC,
                 Prediction, PredictedTarget, exp_pred(Branch, PC), exp_target(PC));
      end
      n_checks++;
      if (BranchCount !== CNT_W'(m_bc) || MissCount !== CNT_W'(m_mc)) begin
        n_fail++;
        $display("FAIL rand_stats it=%0d got bc=%0d mc=%0d exp bc=%0d mc=%0d", n,
                 BranchCount, MissCount, m_bc, m_mc);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    Branch = 1'b1;
    PC     = 32'h620;
    set_update(32'h620, 1'b1, 32'h6c0, 1'b0);
    tick();
    set_update(32'h620, 1'b1, 32'h6f0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Prediction !== 1'b0 || PredictedTarget !== 32'h0 || BranchCount !== 4'd0 || MissCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async got pred=%0b tgt=%h bc=%0d mc=%0d exp all 0",
               Prediction, PredictedTarget, BranchCount, MissCount);
    end
    tick();
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (Prediction !== exp_pred(Branch, PC) || PredictedTarget !== exp_target(PC) ||
        BranchCount !== CNT_W'(m_bc) || MissCount !== CNT_W'(m_mc)) begin
      n_fail++;
      $display("FAIL reset_mid_release got pred=%0b tgt=%h bc=%0d mc=%0d exp pred=0 tgt=0 bc=0 mc=0",
               Prediction, PredictedTarget, BranchCount, MissCount);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_alias();
    test_saturation();
    test_flush();
    test_stats_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
